// File: rtl/disp_sched.sv
// disp_sched: round-robin scheduler sharing a 4-digit seven-segment display between two producers.
// Define DISP_SCHED_BLANK_EN to insert a blank gap of BLANK_CYCLES between consecutive values.

module disp_sched #(
    parameter int HOLD_W       = 26,
    parameter int HOLD_CYCLES  = 50000000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req0_number,
    input  logic [15:0] req1_number,
    output logic [1:0]  req_ready,
    output logic        disp_en,
    output logic [15:0] disp_number,
    output logic        disp_src
);

    // state   | meaning
    // IDLE    | nothing shown, waiting for the first request
    // ARB     | one cycle: winner acknowledged, its value latched on exit
    // SHOW    | value on screen, hold counter running or expired
    // BLANK   | display dark between two values (DISP_SCHED_BLANK_EN only)
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_SHOW  = 2'd2,
        S_BLANK = 2'd3
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
`ifdef DISP_SCHED_BLANK_EN
    localparam logic [HOLD_W-1:0] BLANK_LOAD = HOLD_W'(BLANK_CYCLES - 1);
`endif

    if (HOLD_CYCLES < 1 || 64'(HOLD_CYCLES) > (64'd1 << HOLD_W)) begin : g_hold_chk
        $error("disp_sched: HOLD_CYCLES must be >= 1 and fit in HOLD_W");
    end
    if (BLANK_CYCLES < 1 || 64'(BLANK_CYCLES) > (64'd1 << HOLD_W)) begin : g_blank_chk
        $error("disp_sched: BLANK_CYCLES must be >= 1 and fit in HOLD_W");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [HOLD_W-1:0]  r_cnt;
    logic [HOLD_W-1:0]  w_cnt_nxt;
    logic [1:0]         r_ready;
    logic [1:0]         w_ready_nxt;
    logic               r_en;
    logic               w_en_nxt;
    logic [15:0]        r_number;
    logic [15:0]        w_number_nxt;
    logic               r_src;
    logic               w_src_nxt;
    logic               r_last_grant;
    logic               w_last_nxt;
    logic               w_any;
    logic               w_win;
    logic               w_cnt_zero;

    assign w_any      = |req_valid;
    assign w_cnt_zero = (r_cnt == '0);
    // Only a tie consults the round-robin pointer; a lone requester always wins.
    assign w_win      = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_ARB;
                end
            end
            S_ARB: begin
                w_state_nxt = (r_ready != 2'b00) ? S_SHOW : S_IDLE;
            end
            S_SHOW: begin
                if (w_cnt_zero && w_any) begin
`ifdef DISP_SCHED_BLANK_EN
                    w_state_nxt = S_BLANK;
`else
                    w_state_nxt = S_ARB;
`endif
                end
            end
`ifdef DISP_SCHED_BLANK_EN
            S_BLANK: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_ARB;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered outputs are computed one cycle ahead so they line up with the state they belong to.
    always_comb begin
        w_ready_nxt  = 2'b00;
        w_en_nxt     = (w_state_nxt == S_SHOW);
        w_number_nxt = r_number;
        w_src_nxt    = r_src;
        w_last_nxt   = r_last_grant;
        w_cnt_nxt    = r_cnt;

        if (w_state_nxt == S_ARB && w_any) begin
            w_ready_nxt = w_win ? 2'b10 : 2'b01;
        end

        case (r_state)
            S_ARB: begin
                if (r_ready != 2'b00) begin
                    w_number_nxt = r_ready[1] ? req1_number : req0_number;
                    w_src_nxt    = r_ready[1];
                    w_last_nxt   = r_ready[1];
                    w_cnt_nxt    = HOLD_LOAD;
                end
            end
            S_SHOW: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
`ifdef DISP_SCHED_BLANK_EN
                else if (w_any) begin
                    w_cnt_nxt = BLANK_LOAD;
                end
`endif
            end
`ifdef DISP_SCHED_BLANK_EN
            S_BLANK: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready      <= 2'b00;
            r_en         <= 1'b0;
            r_number     <= 16'h0000;
            r_src        <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
        end else begin
            r_ready      <= w_ready_nxt;
            r_en         <= w_en_nxt;
            r_number     <= w_number_nxt;
            r_src        <= w_src_nxt;
            r_last_grant <= w_last_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    assign req_ready   = r_ready;
    assign disp_en     = r_en;
    assign disp_number = r_number;
    assign disp_src    = r_src;

endmodule

// File: tb/tb_disp_sched.sv
// tb_disp_sched: directed bench for disp_sched with a time-based reference model.
// Works in both builds; the blank gap length follows DISP_SCHED_BLANK_EN.

module tb_disp_sched;

    localparam int HOLD  = 4;
    localparam int BLANK = 2;
`ifdef DISP_SCHED_BLANK_EN
    localparam int GAP = BLANK;
`else
    localparam int GAP = 0;
`endif
    localparam int PERIOD = HOLD + GAP + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req0_number;
    logic [15:0] req1_number;
    logic [1:0]  req_ready;
    logic        disp_en;
    logic [15:0] disp_number;
    logic        disp_src;

    disp_sched #(
        .HOLD_W      (8),
        .HOLD_CYCLES (HOLD),
        .BLANK_CYCLES(BLANK)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req0_number(req0_number),
        .req1_number(req1_number),
        .req_ready  (req_ready),
        .disp_en    (disp_en),
        .disp_number(disp_number),
        .disp_src   (disp_src)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    // Model: a value shown since m_show_t may be replaced once HOLD cycles have passed;
    // the replacement is acknowledged GAP cycles after the request is seen, display dark meanwhile.
    bit          m_shown;
    bit          m_dark;
    bit          m_latched;
    int          m_show_t;
    int          m_ack;
    logic [1:0]  m_ready;
    logic        m_en;
    logic        m_src;
    logic        m_last;
    logic [15:0] m_num;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_shown = 0; m_dark = 0; m_ack = -1;
            m_ready = 2'b00; m_en = 1'b0; m_src = 1'b0; m_last = 1'b1; m_num = 16'h0000;
        end else begin
            m_latched = 0;
            if (m_ack == cyc - 1) begin
                if (m_ready != 2'b00) begin
                    m_src     = m_ready[1];
                    m_last    = m_ready[1];
                    m_num     = m_ready[1] ? req1_number : req0_number;
                    m_shown   = 1;
                    m_show_t  = cyc;
                    m_latched = 1;
                end else begin
                    m_shown = 0;
                end
                m_dark = 0;
                m_ack  = -1;
            end
            m_ready = 2'b00;
            if (!m_latched && m_ack < 0 && req_valid != 2'b00) begin
                if (!m_shown) begin
                    m_ack = cyc;
                end else if (cyc >= m_show_t + HOLD) begin
                    m_ack  = cyc + GAP;
                    m_dark = 1;
                end
            end
            if (m_ack == cyc) begin
                if (req_valid == 2'b11) m_ready = m_last ? 2'b01 : 2'b10;
                else                    m_ready = req_valid;
            end
            m_en = m_shown && !m_dark;
        end
    end

    int g_cyc[$];
    int g_src[$];
    int ack_cnt0 = 0;
    int ack_cnt1 = 0;

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("req_ready", 32'(req_ready), 32'(m_ready));
            check("disp_en", 32'(disp_en), 32'(m_en));
            check("disp_number", 32'(disp_number), 32'(m_num));
            check("disp_src", 32'(disp_src), 32'(m_src));
            check("ready_without_valid", 32'(req_ready & ~req_valid), 32'd0);
        end
        if (req_ready != 2'b00) begin
            g_cyc.push_back(cyc);
            g_src.push_back(int'(req_ready[1]));
        end
        if (req_ready[0]) ack_cnt0++;
        if (req_ready[1]) ack_cnt1++;
    end

    // Requesters hold valid/number through the acknowledge cycle and update just after its closing edge.
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int used0 = 0;
    int used1 = 0;

    task automatic step(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
            if (ack_cnt0 != used0) begin
                used0 = ack_cnt0;
                if (q0.size() > 0) req0_number = q0.pop_front();
                else               req_valid[0] = 1'b0;
            end
            if (ack_cnt1 != used1) begin
                used1 = ack_cnt1;
                if (q1.size() > 0) req1_number = q1.pop_front();
                else               req_valid[1] = 1'b0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    int base;
    int exp_order[6] = '{0, 1, 0, 1, 0, 1};

    initial begin
        // Reset with both requesting, then contention.
        rst = 1'b1; req_valid = 2'b11; req0_number = 16'hAAAA; req1_number = 16'h5555;
        step(3);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_en", 32'(disp_en), 32'd0);
        check("rst_number", 32'(disp_number), 32'd0);
        rst = 1'b0;
        step(2 * PERIOD + 4);
        check("contention_grants", 32'(g_cyc.size()), 32'd2);
        if (g_cyc.size() == 2) begin
            check("contention_first_src", 32'(g_src[0]), 32'd0);
            check("contention_second_src", 32'(g_src[1]), 32'd1);
            check("contention_spacing", 32'(g_cyc[1] - g_cyc[0]), 32'(PERIOD));
        end
        check("contention_number", 32'(disp_number), 32'h5555);
        check("contention_src", 32'(disp_src), 32'd1);

        // Single request held indefinitely.
        rst = 1'b1; step(1); rst = 1'b0;
        base = g_cyc.size();
        req0_number = 16'h1234; req_valid = 2'b01;
        step(1);
        check("single_ready", 32'(req_ready), 32'h1);
        step(1);
        check("single_ready_once", 32'(req_ready), 32'h0);
        check("single_en", 32'(disp_en), 32'd1);
        check("single_number", 32'(disp_number), 32'h1234);
        step(20);
        check("single_held_en", 32'(disp_en), 32'd1);
        check("single_held_number", 32'(disp_number), 32'h1234);
        check("single_grants", 32'(g_cyc.size() - base), 32'd1);

        // Fairness: both re-request immediately after each acknowledge.
        rst = 1'b1; step(1); rst = 1'b0;
        base = g_cyc.size();
        q0 = '{16'h0101, 16'h0102};
        q1 = '{16'h0201, 16'h0202};
        req0_number = 16'h0100; req1_number = 16'h0200; req_valid = 2'b11;
        step(6 * PERIOD + 6);
        check("fair_grants", 32'(g_cyc.size() - base), 32'd6);
        if (g_cyc.size() - base == 6) begin
            for (int k = 0; k < 6; k++) begin
                check($sformatf("fair_order_%0d", k), 32'(g_src[base + k]), 32'(exp_order[k]));
            end
        end
        check("fair_last_number", 32'(disp_number), 32'h0202);

        // Late request after the hold has expired.
        rst = 1'b1; step(1); rst = 1'b0;
        req1_number = 16'hBEEF; req_valid = 2'b10;
        step(12);
        check("late_shown", 32'(disp_number), 32'hBEEF);
        req0_number = 16'h0F0F; req_valid[0] = 1'b1;
        step(1);
        check("late_dark_start", 32'(disp_en), 32'd0);
        step(GAP);
        check("late_ack", 32'(req_ready), 32'h1);
        step(1);
        check("late_new_en", 32'(disp_en), 32'd1);
        check("late_new_number", 32'(disp_number), 32'h0F0F);

        // Reset while the display is dark between values.
        req1_number = 16'h7777; req_valid[1] = 1'b1;
        step(HOLD);
        check("gap_dark", 32'(disp_en), 32'd0);
        rst = 1'b1;
        step(1);
        check("gap_rst_ready", 32'(req_ready), 32'd0);
        check("gap_rst_number", 32'(disp_number), 32'd0);
        check("gap_rst_src", 32'(disp_src), 32'd0);
        rst = 1'b0;
        step(PERIOD + 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_sched.md
# disp_sched

Display scheduler that shares the 4-digit seven-segment display driver between two producers of 16-bit values, e.g. the delay-measurement result and a status/debug word. Each producer offers a value with a valid/ready handshake. The block arbitrates round-robin, latches the winning value and presents it to the display driver's `number`/`en` inputs. Every accepted value is held on screen for a minimum time, and the display is optionally blanked briefly between values so a change stays visible even when two consecutive values are identical.

## Interface
Parameters:
- `HOLD_W`, default 26: width of the hold/blank down-counter.
- `HOLD_CYCLES`, default 50000000: minimum number of `clk` cycles an accepted value is shown. Must be ≥1 and fit in `HOLD_W`.
- `BLANK_CYCLES`, default 1000: length in cycles of the blank gap between values. Must be ≥1 and fit in `HOLD_W`.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous active-high reset.
- `req_valid`, in, 2: bit i is high while requester i offers a value.
- `req0_number`, in, 16: value offered by requester 0.
- `req1_number`, in, 16: value offered by requester 1.
- `req_ready`, out, 2: bit i is high for exactly one cycle when requester i's value is accepted.
- `disp_en`, out, 1: enable to the display driver.
- `disp_number`, out, 16: value to display (4 hex nibbles).
- `disp_src`, out, 1: index of the requester whose value is in `disp_number`.

## Operation
- States: IDLE, ARB, SHOW, BLANK.
- All outputs are registered.
- Reset values: state IDLE; `req_ready` = 0; `disp_en` = 0; `disp_number` = 0; `disp_src` = 0; `last_grant` = 1, so requester 0 wins the first tie.
- IDLE: `disp_en` = 0. If any `req_valid` bit is set, go to ARB.
- ARB (exactly one cycle):
  - Winner is the single valid requester. If both are valid, the winner is `~last_grant`.
  - `req_ready[winner]` = 1; the transfer completes in this cycle.
  - `disp_number` ← the winner's number, `disp_src` ← winner, `last_grant` ← winner.
  - Load the counter with `HOLD_CYCLES`−1 and go to SHOW.
  - If no valid bit is set in ARB (a protocol violation), go to IDLE without asserting `req_ready`.
- SHOW: `disp_en` = 1.
  - While the counter is nonzero, decrement it.
  - At zero with no `req_valid`: stay in SHOW and keep showing the value indefinitely.
  - At zero with any `req_valid`: load `BLANK_CYCLES`−1 and go to BLANK.
- BLANK: `disp_en` = 0 and `disp_number` is unchanged. Decrement the counter; at zero, go to ARB.
- Requester rule: once `req_valid[i]` rises, it stays high with a stable number until `req_ready[i]`. A request is never lost or duplicated.
- Requests arriving while the counter is nonzero in SHOW are not acknowledged until the hold time ends.
- Reset mid-operation (any state): the next cycle shows the reset values. A pending request is re-arbitrated after reset, starting from `last_grant` = 1.

## Timing
- `req_valid` is sampled high in IDLE at edge k → ARB during cycle k+1 (`req_ready` high) → SHOW from cycle k+2 with the new `disp_number` and `disp_en` = 1.
- SHOW lasts at least `HOLD_CYCLES` cycles.
- Value change with a request already pending at hold expiry: last SHOW cycle → BLANK for `BLANK_CYCLES` cycles → ARB for 1 cycle → new value in SHOW.
  - `disp_en` is low for `BLANK_CYCLES`+1 cycles.
- Under continuous requests, `req_ready` pulses every `HOLD_CYCLES`+`BLANK_CYCLES`+1 cycles.

## Configuration
- `DISP_SCHED_BLANK_EN` defined: the BLANK state exists and operates as above.
- `DISP_SCHED_BLANK_EN` undefined:
  - BLANK is removed, and SHOW at zero with a pending request goes directly to ARB.
  - `disp_en` is low only for the single ARB cycle.
  - `BLANK_CYCLES` is ignored.

## Test plan
Use `HOLD_CYCLES`=4 and `BLANK_CYCLES`=2 unless stated otherwise.
- Reset: assert `rst` for 2 cycles with `req_valid`=2'b11 → all outputs are 0 during reset; the first grant after release goes to requester 0.
- Single request: requester 0 offers 0x1234 at edge k → `req_ready`=01 in cycle k+1 only; `disp_number`=0x1234 and `disp_en`=1 from k+2; the value is held indefinitely with no further requests.
- Contention: both valid, 0xAAAA/0x5555 → 0xAAAA shown for 4 cycles, `disp_en` low for 3 cycles, then 0x5555 with `disp_src`=1; `req_ready`[1] pulses 7 cycles after `req_ready`[0].
- Fairness: both requesters re-request immediately after each ack for 6 grants → grant order 0,1,0,1,0,1; no `req_ready` for a requester whose `req_valid` is low.
- Late request: requester 1 raises valid 10 cycles into SHOW (hold already expired) → BLANK on the next cycle, new value shown 3 cycles later.
- Reset in BLANK, and macro-off build: `rst` during BLANK → outputs reset the next cycle. With `DISP_SCHED_BLANK_EN` undefined, the gap between consecutive values is exactly 1 cycle of `disp_en`=0.
